line_mem_arbiter: RTL and testbench
===================================

# line_mem_arbiter

Three-requester arbiter that shares the single-port state-line memory (25 words × 25 bits) between the input loader (requester 0), the rotation/permutation controller datapath (requester 1) and the output unloader (requester 2). Grants are registered and rotate round-robin. A per-grant hold counter bounds the tenure of an unlocked owner. The arbiter forwards the owner's address, write data and command to the memory and tags 1-cycle-latency read data back to the requester that issued the read.

## Interface
Parameters:
- ADDR_W, 5, memory address width
- DATA_W, 25, memory word width
- DEPTH, 25, number of valid words; legal addresses are 0..DEPTH-1
- MAX_HOLD, 8, cycles an unlocked owner may keep the grant while another requester waits

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- req  in  3  request, one bit per requester; held high for the whole tenure
- lock  in  3  per-requester no-preempt qualifier; sampled only while that requester is owner
- addr0/addr1/addr2  in  ADDR_W  requester address
- wdata0/wdata1/wdata2  in  DATA_W  requester write data
- we  in  3  per-requester write strobe (1 = write, 0 = read), valid only when req=1
- gnt  out  3  one-hot registered grant
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write enable
- mem_re  out  1  memory read enable
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_re
- rdata  out  DATA_W  registered copy of mem_rdata, broadcast to all requesters
- rvalid  out  3  one-hot; rdata belongs to this requester
- err  out  1  1-cycle pulse on an out-of-range access

## Operation
- State machine:
  - IDLE: gnt=0.
  - OWN: gnt=one-hot of owner.
  - Transitions:
    - IDLE→OWN when any req=1.
    - OWN→OWN(new owner) on release or preempt when another req is pending.
    - OWN→IDLE on release when no other req is pending.
- Round-robin: a 2-bit last-owner pointer ptr. Search order is ptr+1, ptr+2, ptr (mod 3). The first requester with req=1 wins. ptr loads the new owner on every grant.
- Release: owner's req=0 at a clock edge; the grant moves at that edge. There is no idle gap between owners.
- Hold counter (width ≥ clog2(MAX_HOLD)+1):
  - Clears on each new grant.
  - Increments each OWN cycle and saturates at MAX_HOLD.
  - Preempt when hold=MAX_HOLD-1, lock[owner]=0 and another req is pending.
  - With lock[owner]=1, no preemption occurs regardless of hold count.
- Access: in OWN with req[owner]=1:
  - mem_addr, mem_wdata and mem_we=we[owner] are driven combinationally from the owner.
  - mem_re=~we[owner].
  - When not accessing, mem_we=mem_re=0 and mem_addr/mem_wdata=0.
- Out-of-range: if addr[owner] ≥ DEPTH, mem_we and mem_re are forced to 0 and err pulses on the next cycle. No rvalid is produced.
- Read return: on a read, the owner index is registered. The next cycle gives rdata=mem_rdata registered and rvalid[index]=1. This still happens if the grant has already moved.
- Non-owner inputs are ignored.

## Timing
- Reset (rst=0, asynchronous) sets:
  - gnt=0, state=IDLE, ptr=2 (so requester 0 has first priority), hold=0.
  - rvalid=0, rdata=0, err=0.
  - mem_we=mem_re=0.
  - Reset asserted mid-access aborts immediately with no write; an in-flight rvalid is dropped.
- Grant latency: req rises at edge n → gnt at edge n+1. First memory access is in cycle n+1.
- Read latency: mem_re in cycle k → rvalid/rdata valid in cycle k+2 (memory 1 cycle + output register 1 cycle).
- Simultaneous events:
  - Release and preempt in the same cycle are both treated as release.
  - req rising for the current owner's successor in the release cycle is included in the search.
- Maximum unlocked tenure under contention is MAX_HOLD cycles.

## Test plan
- Reset then req=3'b111 held, lock=0, MAX_HOLD=8 → gnt sequence 001 (8 cycles), 010 (8), 100 (8), 001; no gap cycles.
- Single requester 1: write addr 5 data 25'h1ABCDEF, then read addr 5 → mem_we in grant cycle; rvalid=010 with rdata=25'h1ABCDEF two cycles after mem_re.
- Requester 0 lock=1 holding 20 cycles with req1 pending → gnt stays 001 all 20 cycles; gnt=010 on the edge after req0 falls.
- Requester 2 access to addr 25 and 31 → mem_we=mem_re=0, err pulses once per access, no rvalid.
- Read by 0 in its last cycle, grant moves to 1 → rvalid=001 with correct data while gnt=010.
- rst driven low mid-burst (async, between edges) → gnt, mem_we, rvalid go 0 immediately; after release, req=3'b110 → first gnt=010.

Source files
------------

// File: rtl/line_mem_arbiter.sv
// Purpose: round-robin arbiter sharing the single-port state-line memory between loader, datapath and unloader.
// Latency: grant 1 cycle after req; read data/rvalid 2 cycles after mem_re (memory + output register).
// Backpressure: requesters hold req until granted; an unlocked owner is preempted after MAX_HOLD cycles under contention.
module line_mem_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 25,
  parameter int DEPTH    = 25,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        req,
  input  logic [2:0]        lock,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  input  logic [2:0]        we,
  output logic [2:0]        gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic [2:0]        rvalid,
  output logic              err
);

  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  logic [0:0]        state, state_nxt;
  logic [1:0]        ptr, ptr_nxt;       // last/current owner index
  logic [HOLD_W-1:0] hold;
  logic              grant_evt;

  logic [2:0]        owner_oh;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic              own_req, own_we, own_lock;
  logic              access, in_range;

  logic [2:0]        search_req;
  logic [1:0]        c1, c2, win;
  logic              found;
  logic              release_own, preempt;

  logic              rd_pend;
  logic [1:0]        rd_idx;

  function automatic logic [2:0] oh3(input logic [1:0] i);
    case (i)
      2'd0:    oh3 = 3'b001;
      2'd1:    oh3 = 3'b010;
      default: oh3 = 3'b100;
    endcase
  endfunction

  assign owner_oh = oh3(ptr);
  assign own_req  = |(req  & owner_oh);
  assign own_we   = |(we   & owner_oh);
  assign own_lock = |(lock & owner_oh);

  // Select the owner's address and write data; non-owner inputs never reach the memory.
  always_comb begin
    own_addr  = '0;
    own_wdata = '0;
    case (ptr)
      2'd0: begin own_addr = addr0; own_wdata = wdata0; end
      2'd1: begin own_addr = addr1; own_wdata = wdata1; end
      default: begin own_addr = addr2; own_wdata = wdata2; end
    endcase
  end

  assign access   = (state == ST_OWN) && own_req;
  assign in_range = ({1'b0, own_addr} < DEPTH_C);

  // While owning, the owner is masked out so a release/preempt always moves to someone else.
  assign search_req = (state == ST_OWN) ? (req & ~owner_oh) : req;
  assign c1 = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
  assign c2 = (c1  == 2'd2) ? 2'd0 : c1  + 2'd1;

  // Round-robin search in order ptr+1, ptr+2, ptr.
  always_comb begin
    found = 1'b1;
    win   = ptr;
    if (|(search_req & oh3(c1)))       win = c1;
    else if (|(search_req & oh3(c2)))  win = c2;
    else if (|(search_req & owner_oh)) win = ptr;
    else                               found = 1'b0;
  end

  assign release_own = (state == ST_OWN) && !own_req;
  // >= rather than == so an owner that was locked past the limit can still be preempted once it unlocks.
  assign preempt     = (state == ST_OWN) && own_req && !own_lock && (hold >= HOLD_LAST) && found;

  // Next owner / state; release wins over preempt but both lead to the same search.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    grant_evt = 1'b0;
    if (state == ST_IDLE) begin
      if (found) begin
        state_nxt = ST_OWN;
        ptr_nxt   = win;
        grant_evt = 1'b1;
      end
    end else if (release_own || preempt) begin
      if (found) begin
        ptr_nxt   = win;
        grant_evt = 1'b1;
      end else begin
        state_nxt = ST_IDLE;
      end
    end
  end

  // Grant state, pointer and registered one-hot grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      ptr   <= 2'd2;
      gnt   <= 3'b000;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      gnt   <= (state_nxt == ST_OWN) ? oh3(ptr_nxt) : 3'b000;
    end
  end

  // Tenure counter: cleared per grant, counts owned cycles, saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold <= '0;
    end else if (grant_evt || state == ST_IDLE) begin
      hold <= '0;
    end else if (hold != HOLD_MAX) begin
      hold <= hold + 1'b1;
    end
  end

  // Memory command driven straight from the owner; out-of-range addresses are suppressed.
  always_comb begin
    mem_addr  = access ? own_addr  : '0;
    mem_wdata = access ? own_wdata : '0;
    mem_we    = access &&  own_we && in_range;
    mem_re    = access && !own_we && in_range;
  end

  // Read-return tagging and error pulse; the tag survives a grant change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend <= 1'b0;
      rd_idx  <= 2'd0;
      rdata   <= '0;
      rvalid  <= 3'b000;
      err     <= 1'b0;
    end else begin
      rd_pend <= mem_re;
      if (mem_re) rd_idx <= ptr;
      err     <= access && !in_range;
      rvalid  <= rd_pend ? oh3(rd_idx) : 3'b000;
      if (rd_pend) rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_line_mem_arbiter.sv
module tb_line_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req = '0, lock = '0, we = '0;
  logic [4:0]  addr0 = '0, addr1 = '0, addr2 = '0;
  logic [24:0] wdata0 = '0, wdata1 = '0, wdata2 = '0;
  logic [2:0]  gnt, rvalid;
  logic [4:0]  mem_addr;
  logic [24:0] mem_wdata, mem_rdata, rdata;
  logic        mem_we, mem_re, err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  line_mem_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .we(we), .gnt(gnt), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .rdata(rdata), .rvalid(rvalid), .err(err)
  );

  // Memory model: 32 slots, preloaded with 0x1555000|index on reset, 1-cycle read.
  logic [24:0] mem [0:31];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= 25'h1555000 | 25'(i);
      mem_rdata <= '0;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance to the next cycle and settle combinational outputs.
  task automatic cyc();
    @(posedge clk);
    #4;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0; lock = '0; we = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt",    32'(gnt),    32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rdata",  32'(rdata),  32'h0);
    chk("rst_err",    32'(err),    32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_re", 32'(mem_re), 32'h0);
    rst = 1'b1;
  endtask

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  we;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [24:0] d;
    logic [2:0]  e_gnt;
    logic        e_we;
    logic        e_re;
    logic [4:0]  e_addr;
    logic [2:0]  e_rv;
    logic [24:0] e_rd;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(logic [2:0] rq, logic [2:0] w, logic [4:0] a1, logic [4:0] a2,
                              logic [24:0] d, logic [2:0] g, logic ew, logic er, logic [4:0] ea,
                              logic [2:0] rv, logic [24:0] rd, logic e);
    vec_t v;
    v.req = rq; v.we = w; v.a1 = a1; v.a2 = a2; v.d = d;
    v.e_gnt = g; v.e_we = ew; v.e_re = er; v.e_addr = ea;
    v.e_rv = rv; v.e_rd = rd; v.e_err = e;
    return v;
  endfunction

  localparam int NV = 11;
  vec_t tv [0:NV-1];

  initial begin
    logic [2:0] eg;

    // Requester 1 write/read of addr 5, then requester 2 out-of-range and in-range accesses.
    tv[0]  = mk(3'b010, 3'b010, 5'd5, 5'd0,  25'h1ABCDEF, 3'b000, 0, 0, 5'd0,  3'b000, 25'h0,       0);
    tv[1]  = mk(3'b010, 3'b010, 5'd5, 5'd0,  25'h1ABCDEF, 3'b010, 1, 0, 5'd5,  3'b000, 25'h0,       0);
    tv[2]  = mk(3'b010, 3'b000, 5'd5, 5'd0,  25'h0000000, 3'b010, 0, 1, 5'd5,  3'b000, 25'h0,       0);
    tv[3]  = mk(3'b000, 3'b000, 5'd5, 5'd0,  25'h0000000, 3'b010, 0, 0, 5'd0,  3'b000, 25'h0,       0);
    tv[4]  = mk(3'b000, 3'b000, 5'd5, 5'd0,  25'h0000000, 3'b000, 0, 0, 5'd0,  3'b010, 25'h1ABCDEF, 0);
    tv[5]  = mk(3'b100, 3'b000, 5'd0, 5'd25, 25'h0000000, 3'b000, 0, 0, 5'd0,  3'b000, 25'h0,       0);
    tv[6]  = mk(3'b100, 3'b000, 5'd0, 5'd25, 25'h0000000, 3'b100, 0, 0, 5'd0,  3'b000, 25'h0,       0);
    tv[7]  = mk(3'b100, 3'b000, 5'd0, 5'd3,  25'h0000000, 3'b100, 0, 1, 5'd3,  3'b000, 25'h0,       1);
    tv[8]  = mk(3'b100, 3'b100, 5'd0, 5'd31, 25'h0000000, 3'b100, 0, 0, 5'd0,  3'b000, 25'h0,       0);
    tv[9]  = mk(3'b000, 3'b000, 5'd0, 5'd0,  25'h0000000, 3'b100, 0, 0, 5'd0,  3'b100, 25'h1555003, 1);
    tv[10] = mk(3'b000, 3'b000, 5'd0, 5'd0,  25'h0000000, 3'b000, 0, 0, 5'd0,  3'b000, 25'h0,       0);

    do_reset();
    addr0 = 5'd4; wdata0 = 25'h0DEAD00;
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      req = tv[i].req; we = tv[i].we; lock = 3'b000;
      addr1 = tv[i].a1; addr2 = tv[i].a2;
      wdata1 = tv[i].d; wdata2 = tv[i].d ^ 25'h1FFFFFF;
      #3;
      chk($sformatf("v%0d_gnt", i),    32'(gnt),    32'(tv[i].e_gnt));
      chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(tv[i].e_we));
      chk($sformatf("v%0d_mem_re", i), 32'(mem_re), 32'(tv[i].e_re));
      chk($sformatf("v%0d_rvalid", i), 32'(rvalid), 32'(tv[i].e_rv));
      chk($sformatf("v%0d_err", i),    32'(err),    32'(tv[i].e_err));
      if (tv[i].e_we || tv[i].e_re)
        chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(tv[i].e_addr));
      if (tv[i].e_we)
        chk($sformatf("v%0d_mem_wdata", i), 32'(mem_wdata), 32'(tv[i].d));
      if (tv[i].e_rv != 3'b000)
        chk($sformatf("v%0d_rdata", i), 32'(rdata), 32'(tv[i].e_rd));
    end

    // Full contention, unlocked: 8 cycles each, no gaps, wraps back to requester 0.
    do_reset();
    addr0 = 5'd1; addr1 = 5'd2; addr2 = 5'd3;
    for (int c = 0; c <= 25; c++) begin
      @(posedge clk);
      #1;
      req = 3'b111; lock = 3'b000; we = 3'b000;
      #3;
      if (c == 0)       eg = 3'b000;
      else if (c <= 8)  eg = 3'b001;
      else if (c <= 16) eg = 3'b010;
      else if (c <= 24) eg = 3'b100;
      else              eg = 3'b001;
      chk($sformatf("rr_c%0d_gnt", c), 32'(gnt), 32'(eg));
    end

    // Locked owner keeps the grant for 20 cycles, then hands over right after releasing.
    do_reset();
    for (int c = 0; c <= 22; c++) begin
      @(posedge clk);
      #1;
      req = (c <= 20) ? 3'b011 : 3'b010;
      lock = 3'b001; we = 3'b000;
      #3;
      if (c == 0)       eg = 3'b000;
      else if (c <= 21) eg = 3'b001;
      else              eg = 3'b010;
      chk($sformatf("lock_c%0d_gnt", c), 32'(gnt), 32'(eg));
    end

    // Requester 0 reads in its last cycle; its data returns after the grant moved to 1.
    do_reset();
    lock = 3'b000; we = 3'b000; addr0 = 5'd7; addr1 = 5'd9; req = 3'b011;
    repeat (8) cyc();
    chk("last_c8_gnt",     32'(gnt),      32'h1);
    chk("last_c8_mem_re",  32'(mem_re),   32'h1);
    chk("last_c8_addr",    32'(mem_addr), 32'd7);
    cyc();
    chk("last_c9_gnt",     32'(gnt),      32'h2);
    chk("last_c9_addr",    32'(mem_addr), 32'd9);
    cyc();
    chk("last_c10_gnt",    32'(gnt),      32'h2);
    chk("last_c10_rvalid", 32'(rvalid),   32'h1);
    chk("last_c10_rdata",  32'(rdata),    32'h1555007);
    cyc();
    chk("last_c11_rvalid", 32'(rvalid),   32'h2);
    chk("last_c11_rdata",  32'(rdata),    32'h1555009);

    // Asynchronous reset between edges while requester 1 is mid-read burst.
    cyc();
    chk("arst_pre_gnt",    32'(gnt),    32'h2);
    chk("arst_pre_re",     32'(mem_re), 32'h1);
    chk("arst_pre_rvalid", 32'(rvalid), 32'h2);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_gnt",    32'(gnt),    32'h0);
    chk("arst_mem_we", 32'(mem_we), 32'h0);
    chk("arst_mem_re", 32'(mem_re), 32'h0);
    chk("arst_rvalid", 32'(rvalid), 32'h0);
    @(posedge clk);
    #1;
    req = 3'b110;
    #1;
    rst = 1'b1;
    #2;
    chk("arst_rel_gnt", 32'(gnt), 32'h0);
    cyc();
    chk("arst_first_gnt", 32'(gnt), 32'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
    $fatal(1);
  end

endmodule
